// File: rtl/simon_key_unscheduler.sv
// Reverse-order round-key generator for SIMON 96/96 decryption.
// Expands the master key forward to k[T-2]/k[T-1], then walks the schedule backwards one key per handshake.
module simon_key_unscheduler #(
  parameter int unsigned N = 48,
  parameter int unsigned M = 2,
  parameter int unsigned T = 52,
  parameter logic [61:0] Z = 62'b10101111011100000011010010011000101000010001111110010110110011
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [N*M-1:0] key,
  output logic           busy,
  output logic           rk_valid,
  input  logic           rk_ready,
  output logic [N-1:0]   rk,
  output logic [6:0]     rk_idx,
  output logic           done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXPAND,
    S_EMIT
  } state_t;

  // Z is written with z[0] leftmost; reversing it lets zb(i) be a plain bit select.
  localparam logic [61:0]  ZR = {<<{Z}};
  localparam logic [N-1:0] C  = {{(N-2){1'b1}}, 2'b00};

  state_t       state;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic [6:0]   cnt;
  logic [N-1:0] fwd_word;
  logic [N-1:0] rev_word;
  logic [5:0]   rev_zi;

  function automatic logic [N-1:0] f_mix(input logic [N-1:0] x);
    return {x[2:0], x[N-1:3]} ^ {x[3:0], x[N-1:4]};
  endfunction

  always_comb begin
    fwd_word = '0;
    rev_zi   = '0;
    rev_word = '0;
    fwd_word = C ^ a ^ f_mix(b) ^ {{(N-1){1'b0}}, ZR[cnt[5:0]]};
    rev_zi   = cnt[5:0] - 6'd2;
    rev_word = C ^ b ^ f_mix(a) ^ {{(N-1){1'b0}}, ZR[rev_zi]};
  end

  assign rk     = b;
  assign rk_idx = cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      a        <= '0;
      b        <= '0;
      cnt      <= '0;
      busy     <= 1'b0;
      rk_valid <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            a     <= key[N-1:0];
            b     <= key[2*N-1:N];
            cnt   <= '0;
            busy  <= 1'b1;
            state <= S_EXPAND;
          end
        end
        S_EXPAND: begin
          a <= b;
          b <= fwd_word;
          if (cnt == 7'(T - 3)) begin
            cnt      <= 7'(T - 1);
            rk_valid <= 1'b1;
            state    <= S_EMIT;
          end else begin
            cnt <= cnt + 7'd1;
          end
        end
        S_EMIT: begin
          if (rk_ready) begin
            if (cnt >= 7'd2) begin
              b   <= a;
              a   <= rev_word;
              cnt <= cnt - 7'd1;
            end else if (cnt == 7'd1) begin
              // k[-1] does not exist, so A is simply left as is.
              b   <= a;
              cnt <= '0;
            end else begin
              rk_valid <= 1'b0;
              busy     <= 1'b0;
              done     <= 1'b1;
              state    <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_simon_key_unscheduler.sv
// Directed bench for simon_key_unscheduler: forward-model scoreboard plus hand-computed boundary keys.
module tb_simon_key_unscheduler;

  localparam logic [95:0] REF_KEY = {48'h0d0c0b0a0908, 48'h050403020100};
  localparam logic [47:0] CC      = 48'hFFFF_FFFF_FFFC;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        rk_ready = 1'b0;
  logic [95:0] key = '0;
  logic        busy, rk_valid, done;
  logic [47:0] rk;
  logic [6:0]  rk_idx;

  logic [61:0] zseq = 62'b10101111011100000011010010011000101000010001111110010110110011;
  logic [47:0] sched [52];
  logic [47:0] obs [52];
  logic [47:0] ref_obs [52];
  int          n_checks = 0;
  int          n_fail = 0;

  simon_key_unscheduler #(.N(48), .M(2), .T(52)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .key(key), .busy(busy),
    .rk_valid(rk_valid), .rk_ready(rk_ready), .rk(rk), .rk_idx(rk_idx), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [47:0] ror48(input logic [47:0] x, input int r);
    return (x >> r) | (x << (48 - r));
  endfunction

  function automatic void build_sched(input logic [95:0] k);
    logic [47:0] t;
    sched[0] = k[47:0];
    sched[1] = k[95:48];
    for (int i = 0; i < 50; i++) begin
      t = sched[i+1];
      sched[i+2] = CC ^ sched[i] ^ ror48(t, 3) ^ ror48(t, 4) ^ {47'b0, zseq[61-i]};
    end
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Starts a run at the current (post-edge) time and returns in the done cycle.
  task automatic run_key(input logic [95:0] k, input bit rand_ready, input bit poke,
                         input logic [95:0] other);
    int e, hs, guard;
    bit rdy, last_rdy, expand_bad, emit_bad, stab_bad;
    logic [47:0] prev_rk;
    logic [6:0]  prev_idx;
    build_sched(k);
    expand_bad = 0; emit_bad = 0; stab_bad = 0;
    start = 1'b1;
    key   = k;
    step();
    start = 1'b0;
    key   = poke ? other : {$urandom, $urandom, $urandom};
    for (int c = 0; c < 50; c++) begin
      if (rk_valid !== 1'b0 || busy !== 1'b1 || done !== 1'b0) expand_bad = 1;
      rk_ready = 1'($urandom_range(0, 1));
      start    = poke ? 1'($urandom_range(0, 1)) : 1'b0;
      step();
    end
    chk("expand_flags", 64'(expand_bad), 64'd0);
    chk("first_valid", 64'(rk_valid), 64'd1);
    chk("first_idx", 64'(rk_idx), 64'd51);
    e = 51; hs = 0; guard = 0; last_rdy = 1;
    prev_rk = '0; prev_idx = '0;
    while (e >= 0 && guard < 1000) begin
      if (rk_valid !== 1'b1 || busy !== 1'b1 || done !== 1'b0) emit_bad = 1;
      if (!last_rdy && (rk !== prev_rk || rk_idx !== prev_idx)) stab_bad = 1;
      rdy      = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      rk_ready = rdy;
      start    = poke ? 1'($urandom_range(0, 1)) : 1'b0;
      if (rdy) begin
        chk("rk_idx", 64'(rk_idx), 64'(e));
        chk("rk", 64'(rk), 64'(sched[e]));
        obs[e] = rk;
        e--;
        hs++;
      end
      prev_rk = rk; prev_idx = rk_idx; last_rdy = rdy;
      step();
      guard++;
    end
    start    = 1'b0;
    rk_ready = 1'b0;
    chk("emit_bound", 64'(guard < 1000), 64'd1);
    chk("handshakes", 64'(hs), 64'd52);
    chk("emit_flags", 64'(emit_bad), 64'd0);
    chk("hold_stable", 64'(stab_bad), 64'd0);
    chk("done_pulse", 64'(done), 64'd1);
    chk("valid_after", 64'(rk_valid), 64'd0);
    chk("busy_after", 64'(busy), 64'd0);
  endtask

  task automatic idle_check;
    start = 1'b0;
    step();
    chk("done_once", 64'(done), 64'd0);
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_valid"}, 64'(rk_valid), 64'd0);
    chk({tag, "_rk"}, 64'(rk), 64'd0);
    chk({tag, "_idx"}, 64'(rk_idx), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
  endtask

  task automatic compare_to_ref(input string tag);
    int diffs = 0;
    for (int i = 0; i < 52; i++) if (obs[i] !== ref_obs[i]) diffs++;
    chk(tag, 64'(diffs), 64'd0);
  endtask

  initial begin
    logic [95:0] k2;
    bit found, done_seen;
    step();
    step();
    check_zero_outputs("reset");
    rst_n = 1'b1;
    step();

    run_key('0, 0, 0, '0);
    chk("zero_k2", 64'(obs[2]), 64'hFFFF_FFFF_FFFD);
    chk("zero_k1", 64'(obs[1]), 64'd0);
    chk("zero_k0", 64'(obs[0]), 64'd0);
    idle_check();

    run_key(REF_KEY, 0, 0, '0);
    chk("ref_k1", 64'(obs[1]), 64'h0d0c0b0a0908);
    chk("ref_k0", 64'(obs[0]), 64'h050403020100);
    for (int i = 0; i < 52; i++) ref_obs[i] = obs[i];
    idle_check();

    run_key(REF_KEY, 1, 0, '0);
    compare_to_ref("backpressure_seq");
    idle_check();

    k2 = {$urandom, $urandom, $urandom};
    run_key(REF_KEY, 0, 1, k2);
    compare_to_ref("poke_seq");
    run_key(k2, 0, 0, '0);
    idle_check();

    start = 1'b1;
    key   = {$urandom, $urandom, $urandom};
    step();
    start = 1'b0;
    repeat (19) step();
    rst_n = 1'b0;
    #1;
    check_zero_outputs("rst_expand");
    step();
    rst_n = 1'b1;
    done_seen = 0;
    repeat (3) begin step(); if (done !== 1'b0) done_seen = 1; end
    chk("rst_expand_nodone", 64'(done_seen), 64'd0);

    start    = 1'b1;
    key      = REF_KEY;
    rk_ready = 1'b1;
    step();
    start = 1'b0;
    found = 0;
    for (int c = 0; c < 200 && !found; c++) begin
      if (rk_valid === 1'b1 && rk_idx === 7'd30) found = 1;
      else step();
    end
    chk("reach_idx30", 64'(found), 64'd1);
    rst_n = 1'b0;
    #1;
    check_zero_outputs("rst_emit");
    rk_ready = 1'b0;
    step();
    rst_n = 1'b1;
    done_seen = 0;
    repeat (3) begin step(); if (done !== 1'b0) done_seen = 1; end
    chk("rst_emit_nodone", 64'(done_seen), 64'd0);
    run_key(REF_KEY, 0, 0, '0);
    compare_to_ref("post_reset_seq");
    idle_check();

    for (int r = 0; r < 200; r++)
      run_key({$urandom, $urandom, $urandom}, (r % 8) == 0, 0, '0);
    idle_check();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/simon_key_unscheduler.md
# simon_key_unscheduler

- **Role:** reverse-order round-key generator for the SIMON 96/96 decryption datapath (N=48, M=2, T=52 rounds).
- **Input:** the master key, the same {k[1], k[0]} packing the forward key schedule consumes.
- **Setup:** expands the key forward once to reach the last two round keys.
- **Output:** streams k[T-1] down to k[0], one per accepted handshake, so the decryption round pipeline can consume keys without storing the full schedule.
- **Placement:** between key load and the inverse round function.

## Interface
- N, 48, word size in bits
- M, 2, key words; only M=2 is supported
- T, 52, rounds / round keys emitted
- Z, 62'b10101111011100000011010010011000101000010001111110010110110011, z2 sequence; string character 0 (leftmost) is z[0]
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  begin a new key; sampled only in IDLE
- key  in  N*M  master key; key[N-1:0]=k[0], key[2N-1:N]=k[1]; latched on the start edge
- busy  out  1  high in EXPAND and EMIT
- rk_valid  out  1  rk/rk_idx hold a valid round key
- rk_ready  in  1  consumer accepts when rk_valid && rk_ready
- rk  out  N  round key k[rk_idx]
- rk_idx  out  7  round index of rk, T-1 down to 0
- done  out  1  one-cycle pulse after k[0] is accepted

## Operation
- **Registers:** A (lower-index word), B (higher-index word), 7-bit counter cnt/idx, 2-bit state.
- **Definitions:**
  - f(x) = ROR(x,3) ^ ROR(x,4)
  - c = 2^N − 4 = 48'hFFFF_FFFF_FFFC
  - zb(i) = Z bit i mod 62, XORed into bit 0
- **Forward step:** k[i+2] = c ^ zb(i) ^ k[i] ^ f(k[i+1])
- **Reverse step:** k[i−1] = k[i+1] ^ c ^ zb(i−1) ^ f(k[i])
- **IDLE:**
  - busy=0, rk_valid=0.
  - On start: A←key[N-1:0], B←key[2N-1:N], cnt←0, go to EXPAND.
- **EXPAND:**
  - Each cycle: A←B, B←c ^ zb(cnt) ^ A ^ f(B), cnt←cnt+1.
  - After the step with cnt=T−3 (50 steps total): A=k[50], B=k[51]. Set idx←T−1 and go to EMIT.
  - start and rk_ready are ignored.
- **EMIT:**
  - rk_valid=1, rk=B, rk_idx=idx.
  - On handshake with idx≥2: B←A, A←B ^ c ^ zb(idx−2) ^ f(A), idx←idx−1.
  - On handshake with idx=1: B←A, A held (don't care), idx←0.
  - On handshake with idx=0: go to IDLE, done←1 for one cycle, rk_valid←0.
  - Without a handshake, rk, rk_idx and rk_valid hold stable.
- **start while busy:** ignored. It neither restarts nor queues.
- **key changes after the start edge:** no effect.
- **All arithmetic:** modulo 2^N on XOR/rotate only; no carries.

## Timing
- **Reset values (asserted asynchronously on rst_n low):** state=IDLE, busy=0, rk_valid=0, rk=0, rk_idx=0, done=0.
- **Deassertion:** the first edge after rst_n rises may sample start.
- **Reset mid-operation:** immediate abort to reset values; no done pulse; the partially emitted schedule is discarded.
- **Latency:** start sampled at edge E0 → busy high after E0 → rk_valid high after edge E50 (50 expand cycles) with rk_idx=51.
- **Throughput:** with rk_ready held high, one key per cycle: idx 51 after E50 … idx 0 after E101. done is high after E102 only; rk_valid is low and busy is low after E102.
- **Back-to-back:** start may be asserted in the cycle done is high. It is sampled at that edge (state is IDLE), so a new run starts with no dead cycle.
- **rk_ready high during EXPAND:** no effect.
- **rk_ready may toggle arbitrarily in EMIT:** the output sequence is identical to the all-ready case; only the timing stretches.
- **Registered outputs:** rk, rk_idx, rk_valid and done are driven directly from registers. Combinational logic is limited to the next-word computation.

## Test plan
- **Reset mid-run:**
  - Stimulus: assert rst_n low at E20 of EXPAND, then again at idx=30 in EMIT.
  - Required: all outputs 0 immediately; no done pulse. A fresh start then runs the full 52-key sequence correctly.
- **Zero key, ready tied high:**
  - Stimulus: key=0.
  - Required:
    - first valid at E50 with rk_idx=51;
    - rk_idx=2 yields rk=48'hFFFF_FFFF_FFFD;
    - rk_idx=1 and rk_idx=0 yield 0;
    - done pulses exactly once, after E102.
- **Reference key, ready tied high:**
  - Stimulus: key={48'h0d0c0b0a0908, 48'h050403020100}.
  - Required: all 52 rk values match the existing forward keyscheduling module, evaluated for i=51..0, in descending order. rk_idx=1 gives 48'h0d0c0b0a0908 and rk_idx=0 gives 48'h050403020100.
- **Random rk_ready backpressure (~50% duty):**
  - Required:
    - rk/rk_idx never change while rk_valid && !rk_ready;
    - the sequence is identical to the ready-high run;
    - exactly 52 handshakes.
- **start pulsed during EXPAND and EMIT with a different key:**
  - Required: ignored; output matches the original key. A start in the done cycle begins the new key with first valid 50 edges later.
- **Random keys, 200 runs, scoreboard vs. forward model:**
  - Required: every key matches; busy is high exactly from E0+1 through the last handshake.
